// File: rtl/rdma_framer.sv
// rdma_framer: turns {len, addr} headers plus write-data beats into framed
// AXI-stream packets (one header beat, then exactly len+1 data beats).
// Short bursts are truncated at the upstream TLAST. The excess beats of long
// bursts are drained without being forwarded.
// Build option: define RDMA_FRAMER_STATS_EN to enable PKT_COUNT, ERR_SHORT
// and ERR_LONG. When it is undefined, those ports are tied to zero.
module rdma_framer #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned HDR_LEN    = ADDR_WIDTH + 8,
    parameter logic [15:0] MAGIC      = 16'hD1CE
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [HDR_LEN-1:0]      AXIS_HDR_TDATA,
    input  logic                    AXIS_HDR_TVALID,
    output logic                    AXIS_HDR_TREADY,
    input  logic [DATA_WIDTH-1:0]   AXIS_IN_TDATA,
    input  logic [DATA_WIDTH/8-1:0] AXIS_IN_TKEEP,
    input  logic                    AXIS_IN_TLAST,
    input  logic                    AXIS_IN_TVALID,
    output logic                    AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0]   AXIS_OUT_TDATA,
    output logic [DATA_WIDTH/8-1:0] AXIS_OUT_TKEEP,
    output logic                    AXIS_OUT_TLAST,
    output logic                    AXIS_OUT_TVALID,
    input  logic                    AXIS_OUT_TREADY,
    output logic [31:0]             PKT_COUNT,
    output logic [15:0]             ERR_SHORT,
    output logic [15:0]             ERR_LONG
);

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAGIC_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;

    logic                    hdr_hs_c;
    logic                    hdr_out_hs_c;
    logic                    data_hs_c;
    logic                    drain_hs_c;
    logic                    pkt_end_c;
    logic [DATA_WIDTH-1:0]   hdr_beat_c;

    // Per-state handshake qualifiers and the assembled header beat
    always_comb begin
        hdr_hs_c     = (state_q == S_IDLE)  && AXIS_HDR_TVALID;
        hdr_out_hs_c = (state_q == S_HDR)   && AXIS_OUT_TREADY;
        data_hs_c    = (state_q == S_DATA)  && AXIS_IN_TVALID && AXIS_OUT_TREADY;
        drain_hs_c   = (state_q == S_DRAIN) && AXIS_IN_TVALID;
        pkt_end_c    = (beat_cnt_q == '0) || AXIS_IN_TLAST;

        hdr_beat_c                            = '0;
        hdr_beat_c[ADDR_WIDTH-1:0]            = addr_q;
        hdr_beat_c[ADDR_WIDTH +: LEN_W]       = len_q;
        hdr_beat_c[ADDR_WIDTH+LEN_W +: MAGIC_W] = MAGIC;
    end

    // State and header/beat-counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state: header capture, beat counting and packet termination
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hdr_hs_c) begin
                    addr_d     = AXIS_HDR_TDATA[ADDR_WIDTH-1:0];
                    len_d      = AXIS_HDR_TDATA[ADDR_WIDTH +: LEN_W];
                    beat_cnt_d = AXIS_HDR_TDATA[ADDR_WIDTH +: LEN_W];
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (hdr_out_hs_c) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (data_hs_c) begin
                    // Counter holds at zero instead of wrapping
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    end
                    if (AXIS_IN_TLAST) begin
                        state_d = S_IDLE;
                    end else if (beat_cnt_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_hs_c && AXIS_IN_TLAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: header beat from registers, data beats passed straight through
    always_comb begin
        AXIS_HDR_TREADY = 1'b0;
        AXIS_IN_TREADY  = 1'b0;
        AXIS_OUT_TVALID = 1'b0;
        AXIS_OUT_TDATA  = '0;
        AXIS_OUT_TKEEP  = '0;
        AXIS_OUT_TLAST  = 1'b0;
        case (state_q)
            S_IDLE: begin
                AXIS_HDR_TREADY = 1'b1;
            end
            S_HDR: begin
                AXIS_OUT_TVALID = 1'b1;
                AXIS_OUT_TDATA  = hdr_beat_c;
                AXIS_OUT_TKEEP  = '1;
            end
            S_DATA: begin
                AXIS_OUT_TVALID = AXIS_IN_TVALID;
                AXIS_OUT_TDATA  = AXIS_IN_TDATA;
                AXIS_OUT_TKEEP  = AXIS_IN_TKEEP;
                AXIS_OUT_TLAST  = pkt_end_c;
                AXIS_IN_TREADY  = AXIS_OUT_TREADY;
            end
            S_DRAIN: begin
                AXIS_IN_TREADY = 1'b1;
            end
            default: ;
        endcase
        // Hold every handshake low while reset is asserted
        if (!resetn) begin
            AXIS_HDR_TREADY = 1'b0;
            AXIS_IN_TREADY  = 1'b0;
            AXIS_OUT_TVALID = 1'b0;
        end
    end

`ifdef RDMA_FRAMER_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] err_short_q, err_short_d;
    logic [15:0] err_long_q,  err_long_d;

    // Packet count wraps; error counts saturate
    always_comb begin
        pkt_count_d = pkt_count_q;
        err_short_d = err_short_q;
        err_long_d  = err_long_q;
        if (data_hs_c && pkt_end_c) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        if (data_hs_c && AXIS_IN_TLAST && (beat_cnt_q != '0) && (err_short_q != 16'hFFFF)) begin
            err_short_d = err_short_q + 16'd1;
        end
        if (data_hs_c && !AXIS_IN_TLAST && (beat_cnt_q == '0) && (err_long_q != 16'hFFFF)) begin
            err_long_d = err_long_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_count_q <= '0;
            err_short_q <= '0;
            err_long_q  <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign PKT_COUNT = pkt_count_q;
    assign ERR_SHORT = err_short_q;
    assign ERR_LONG  = err_long_q;
`else
    assign PKT_COUNT = '0;
    assign ERR_SHORT = '0;
    assign ERR_LONG  = '0;
`endif

endmodule

// File: tb/tb_rdma_framer.sv
// tb_rdma_framer: scoreboard bench for rdma_framer. Bursts are queued as
// stimulus together with their expected framed output. A negedge monitor
// pops the expected beats and compares them against the DUT output.
module tb_rdma_framer;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 64;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned HW = AW + 8;
`ifdef RDMA_FRAMER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic [HW-1:0] AXIS_HDR_TDATA;
    logic          AXIS_HDR_TVALID;
    logic          AXIS_HDR_TREADY;
    logic [DW-1:0] AXIS_IN_TDATA;
    logic [KW-1:0] AXIS_IN_TKEEP;
    logic          AXIS_IN_TLAST;
    logic          AXIS_IN_TVALID;
    logic          AXIS_IN_TREADY;
    logic [DW-1:0] AXIS_OUT_TDATA;
    logic [KW-1:0] AXIS_OUT_TKEEP;
    logic          AXIS_OUT_TLAST;
    logic          AXIS_OUT_TVALID;
    logic          AXIS_OUT_TREADY;
    logic [31:0]   PKT_COUNT;
    logic [15:0]   ERR_SHORT;
    logic [15:0]   ERR_LONG;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int exp_pkt = 0;
    int exp_short = 0;
    int exp_long = 0;

    logic [HW-1:0] hdr_q[$];
    beat_t         beat_q[$];
    beat_t         exp_q[$];
    int            hdr_cyc[$];
    int            out_cyc[$];
    int            last_cyc[$];

    rdma_framer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .HDR_LEN    (HW),
        .MAGIC      (16'hD1CE)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .AXIS_HDR_TDATA  (AXIS_HDR_TDATA),
        .AXIS_HDR_TVALID (AXIS_HDR_TVALID),
        .AXIS_HDR_TREADY (AXIS_HDR_TREADY),
        .AXIS_IN_TDATA   (AXIS_IN_TDATA),
        .AXIS_IN_TKEEP   (AXIS_IN_TKEEP),
        .AXIS_IN_TLAST   (AXIS_IN_TLAST),
        .AXIS_IN_TVALID  (AXIS_IN_TVALID),
        .AXIS_IN_TREADY  (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA  (AXIS_OUT_TDATA),
        .AXIS_OUT_TKEEP  (AXIS_OUT_TKEEP),
        .AXIS_OUT_TLAST  (AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY (AXIS_OUT_TREADY),
        .PKT_COUNT       (PKT_COUNT),
        .ERR_SHORT       (ERR_SHORT),
        .ERR_LONG        (ERR_LONG)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Queue one burst and the packet the framer should make of it
    task automatic send_burst(input logic [7:0] len, input logic [AW-1:0] addr, input int nbeats);
        beat_t b;
        beat_t h;
        int    nout;
        hdr_q.push_back({len, addr});
        h.data         = '0;
        h.data[63:0]   = addr;
        h.data[71:64]  = len;
        h.data[87:72]  = 16'hD1CE;
        h.keep         = '1;
        h.last         = 1'b0;
        exp_q.push_back(h);
        nout = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
        for (int i = 0; i < nbeats; i++) begin
            b.data = rand_data();
            b.keep = {$urandom, $urandom};
            b.last = (i == nbeats - 1);
            beat_q.push_back(b);
            if (i < nout) begin
                b.last = (i == nout - 1);
                exp_q.push_back(b);
            end
        end
        exp_pkt++;
        if (nbeats < int'(len) + 1) exp_short++;
        else if (nbeats > int'(len) + 1) exp_long++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt"},   640'(PKT_COUNT), 640'(STATS ? 32'(exp_pkt)   : 32'd0));
        check({tag, "_short"}, 640'(ERR_SHORT), 640'(STATS ? 16'(exp_short) : 16'd0));
        check({tag, "_long"},  640'(ERR_LONG),  640'(STATS ? 16'(exp_long)  : 16'd0));
    endtask

    // Wait for all stimulus to be consumed and expected output seen, then check counters
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hdr_q.size() != 0 || beat_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 640'(exp_q.size()), 640'(0));
        repeat (3) @(negedge clk);
        check_counters(tag);
        @(posedge clk);
        #2;
    endtask

    // Upstream model: present queue heads, pop on handshake, pattern OUT_TREADY
    initial begin : drv
        logic hdr_fire;
        logic in_fire;
        beat_t bd;
        AXIS_HDR_TVALID = 1'b0;
        AXIS_HDR_TDATA  = '0;
        AXIS_IN_TVALID  = 1'b0;
        AXIS_IN_TDATA   = '0;
        AXIS_IN_TKEEP   = '0;
        AXIS_IN_TLAST   = 1'b0;
        AXIS_OUT_TREADY = 1'b1;
        forever begin
            @(negedge clk);
            hdr_fire = AXIS_HDR_TVALID && AXIS_HDR_TREADY;
            in_fire  = AXIS_IN_TVALID && AXIS_IN_TREADY;
            @(posedge clk);
            #1;
            if (hdr_fire && hdr_q.size() != 0) hdr_q.delete(0);
            if (in_fire && beat_q.size() != 0) beat_q.delete(0);
            if (hdr_q.size() != 0) begin
                AXIS_HDR_TVALID = 1'b1;
                AXIS_HDR_TDATA  = hdr_q[0];
            end else begin
                AXIS_HDR_TVALID = 1'b0;
            end
            if (beat_q.size() != 0) begin
                bd = beat_q[0];
                AXIS_IN_TVALID = 1'b1;
                AXIS_IN_TDATA  = bd.data;
                AXIS_IN_TKEEP  = bd.keep;
                AXIS_IN_TLAST  = bd.last;
            end else begin
                AXIS_IN_TVALID = 1'b0;
            end
            case (rdy_mode)
                1:       AXIS_OUT_TREADY = !AXIS_OUT_TREADY;
                2:       AXIS_OUT_TREADY = 1'($urandom_range(0, 1));
                default: AXIS_OUT_TREADY = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard compare, stall stability, handshake timestamps
    initial begin : mon
        beat_t got;
        beat_t exp;
        logic  stall_prev;
        beat_t stall_beat;
        stall_prev = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk);
            got.data = AXIS_OUT_TDATA;
            got.keep = AXIS_OUT_TKEEP;
            got.last = AXIS_OUT_TLAST;
            if (resetn && stall_prev)
                check("stall_hold", 640'({AXIS_OUT_TVALID, got}), 640'({1'b1, stall_beat}));
            stall_prev = resetn && AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
            stall_beat = got;
            if (resetn && AXIS_HDR_TVALID && AXIS_HDR_TREADY) hdr_cyc.push_back(cyc);
            if (resetn && AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                out_cyc.push_back(cyc);
                if (AXIS_OUT_TLAST) last_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 640'(exp_q.size()), 640'(1));
                end else begin
                    exp = exp_q.pop_front();
                    check("out_beat", 640'(got), 640'(exp));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run still active at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int t_hdr1;
        int t_last0;
        int t_hdr0;
        int t_out0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_handshakes", 640'({AXIS_HDR_TREADY, AXIS_IN_TREADY, AXIS_OUT_TVALID}), 640'(0));
        check_counters("rst");
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        check("idle_handshakes", 640'({AXIS_HDR_TREADY, AXIS_IN_TREADY, AXIS_OUT_TVALID}), 640'(3'b100));
        @(posedge clk);
        #2;

        // Single-beat packet
        send_burst(8'd0, 64'h1000, 1);
        wait_idle("single", 200);

        // Four beats with a toggling downstream ready
        rdy_mode = 1;
        send_burst(8'd3, 64'h2000, 4);
        wait_idle("toggle", 300);
        rdy_mode = 0;

        // Short burst, then a normal one right after
        send_burst(8'd3, 64'h3000, 2);
        wait_idle("short", 200);
        send_burst(8'd0, 64'h3040, 1);
        wait_idle("after_short", 200);

        // Long burst: excess beats drained
        send_burst(8'd1, 64'h4000, 4);
        wait_idle("long", 200);

        // Two headers queued back to back
        hdr_cyc.delete();
        out_cyc.delete();
        last_cyc.delete();
        send_burst(8'd0, 64'h5000, 1);
        send_burst(8'd0, 64'h5100, 1);
        wait_idle("b2b", 200);
        t_hdr0  = (hdr_cyc.size()  > 0) ? hdr_cyc[0]  : -100;
        t_hdr1  = (hdr_cyc.size()  > 1) ? hdr_cyc[1]  : -100;
        t_last0 = (last_cyc.size() > 0) ? last_cyc[0] : -100;
        t_out0  = (out_cyc.size()  > 0) ? out_cyc[0]  : -100;
        check("b2b_out_beats", 640'(out_cyc.size()), 640'(4));
        check("b2b_hdr_latency", 640'(t_out0), 640'(t_hdr0 + 1));
        check("b2b_second_hdr", 640'(t_hdr1), 640'(t_last0 + 1));

        // Reset while data beat 2 of a len=7 burst is on the bus
        out_cyc.delete();
        send_burst(8'd7, 64'h6000, 8);
        n = 0;
        while (out_cyc.size() < 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("midrst_reach_beat2", 640'(out_cyc.size()), 640'(2));
        @(posedge clk);
        #2;
        resetn = 1'b0;
        hdr_q.delete();
        beat_q.delete();
        exp_q.delete();
        exp_pkt   = 0;
        exp_short = 0;
        exp_long  = 0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_handshakes", 640'({AXIS_HDR_TREADY, AXIS_IN_TREADY, AXIS_OUT_TVALID}), 640'(0));
        check_counters("midrst");
        @(posedge clk);
        #2;
        resetn = 1'b1;
        send_burst(8'd0, 64'h7000, 1);
        wait_idle("post_rst", 200);

        // Maximum length and random bursts under random backpressure
        rdy_mode = 2;
        send_burst(8'd255, 64'hFFFF_FFFF_FFFF_FF00, 256);
        wait_idle("len255", 3000);
        for (int i = 0; i < 6; i++) begin
            send_burst(8'($urandom_range(0, 7)), {$urandom, $urandom}, int'($urandom_range(1, 10)));
        end
        wait_idle("random", 3000);
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
